// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: accepts one (row, col, pulses, width) command and drives decoders, enables and injection pulses.
// Latency: outputs registered; enables appear the cycle after accept, done strobes SETTLE_CYC cycles after the last pulse (or abort).
// Backpressure: cmd_ready is high only in IDLE; a held cmd_valid is accepted the cycle after done.
module fg_prog_sequencer #(
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 16,
  parameter int ADDR_W     = 5,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_row,
  input  logic [ADDR_W-1:0] cmd_col,
  input  logic [7:0]        cmd_pulses,
  input  logic [CNT_W-1:0]  cmd_width,
  input  logic              abort,
  output logic [ADDR_W-1:0] dec_v_addr,
  output logic [ADDR_W-1:0] dec_h_addr,
  output logic              dec_v_en,
  output logic              dec_h_en,
  output logic              drain_sel_en,
  output logic              gate_sel_en,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        pulses_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_RELEASE, S_DONE
  } state_t;

  // Timers count down to zero, so each phase loads its duration minus one.
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [ADDR_W:0]   ROWS_LIM  = (ADDR_W+1)'(NUM_ROWS);
  localparam logic [ADDR_W:0]   COLS_LIM  = (ADDR_W+1)'(NUM_COLS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    width_q, width_d;   // pulse length minus one, zero width clamped to one cycle
  logic [7:0]          remain_q, remain_d;  // pulses still to issue, including the one in flight
  logic [7:0]          pcnt_q, pcnt_d;
  logic [ADDR_W-1:0]   v_addr_q, v_addr_d;
  logic [ADDR_W-1:0]   h_addr_q, h_addr_d;
  logic                en_q, en_d;
  logic                prog_q, prog_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                out_of_range;
  logic                timer_zero;

  assign out_of_range = ({1'b0, cmd_row} >= ROWS_LIM) || ({1'b0, cmd_col} >= COLS_LIM);
  assign timer_zero   = (timer_q == '0);

  // State and registered outputs; reset wins over every state, dropping enables and prog_en on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      width_q  <= '0;
      remain_q <= '0;
      pcnt_q   <= '0;
      v_addr_q <= '0;
      h_addr_q <= '0;
      en_q     <= 1'b0;
      prog_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      width_q  <= width_d;
      remain_q <= remain_d;
      pcnt_q   <= pcnt_d;
      v_addr_q <= v_addr_d;
      h_addr_q <= h_addr_d;
      en_q     <= en_d;
      prog_q   <= prog_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state: phase sequencing, phase timers, pulse bookkeeping and command latching.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    width_d  = width_q;
    remain_d = remain_q;
    pcnt_d   = pcnt_q;
    v_addr_d = v_addr_q;
    h_addr_d = h_addr_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else begin
            state_d  = S_SETUP;
            timer_d  = SETTLE_LD;
            v_addr_d = cmd_row;
            h_addr_d = cmd_col;
            remain_d = cmd_pulses;
            width_d  = (cmd_width == '0) ? '0 : cmd_width - 1'b1;
            pcnt_d   = '0;
          end
        end
      end
      S_SETUP: begin
        if (abort || (timer_zero && remain_q == 8'd0)) begin
          state_d = S_RELEASE;
          timer_d = SETTLE_LD;
        end else if (timer_zero) begin
          state_d = S_PULSE;
          timer_d = width_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_PULSE: begin
        // A pulse that reaches its full width is counted even if abort arrives on that same cycle.
        if (timer_zero) begin
          remain_d = remain_q - 8'd1;
          if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
        end
        if (abort || (timer_zero && remain_q == 8'd1)) begin
          state_d = S_RELEASE;
          timer_d = SETTLE_LD;
        end else if (timer_zero) begin
          state_d = S_GAP;
          timer_d = GAP_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_RELEASE;
          timer_d = SETTLE_LD;
        end else if (timer_zero) begin
          state_d = S_PULSE;
          timer_d = width_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RELEASE: begin
        if (timer_zero) state_d = S_DONE;
        else            timer_d = timer_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output lines up with the state it describes.
  always_comb begin
    en_d   = (state_d == S_SETUP) || (state_d == S_PULSE) ||
             (state_d == S_GAP)   || (state_d == S_RELEASE);
    prog_d = (state_d == S_PULSE);
    busy_d = en_d;
    done_d = (state_d == S_DONE);
  end

  assign cmd_ready    = (state_q == S_IDLE) && !rst;
  assign dec_v_addr   = v_addr_q;
  assign dec_h_addr   = h_addr_q;
  assign dec_v_en     = en_q;
  assign dec_h_en     = en_q;
  assign drain_sel_en = en_q;
  assign gate_sel_en  = en_q;
  assign prog_en      = prog_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign pulses_done  = pcnt_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Bench for fg_prog_sequencer: directed test-plan scenarios plus random commands/aborts against a
// per-cycle expected-waveform model built from each command (settle, pulses, gaps, release, done).
module tb_fg_prog_sequencer;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 16;
  localparam int ADDR_W   = 5;
  localparam int SETTLE   = 4;
  localparam int GAP      = 2;
  localparam int CNT_W    = 16;

  localparam int PH_IDLE = 0, PH_SET = 1, PH_PUL = 2, PH_GAP = 3, PH_REL = 4, PH_DONE = 5;

  typedef struct {
    int ph;
    int pd;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_row = '0;
  logic [ADDR_W-1:0] cmd_col = '0;
  logic [7:0]        cmd_pulses = '0;
  logic [CNT_W-1:0]  cmd_width = '0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] dec_v_addr, dec_h_addr;
  logic              dec_v_en, dec_h_en, drain_sel_en, gate_sel_en;
  logic              prog_en, busy, done, err;
  logic [7:0]        pulses_done;

  fg_prog_sequencer #(
    .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .ADDR_W(ADDR_W),
    .SETTLE_CYC(SETTLE), .GAP_CYC(GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_pulses(cmd_pulses), .cmd_width(cmd_width),
    .abort(abort), .dec_v_addr(dec_v_addr), .dec_h_addr(dec_h_addr),
    .dec_v_en(dec_v_en), .dec_h_en(dec_h_en), .drain_sel_en(drain_sel_en),
    .gate_sel_en(gate_sel_en), .prog_en(prog_en), .busy(busy), .done(done),
    .err(err), .pulses_done(pulses_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  rec_t q[$];
  rec_t cur;
  bit   cur_idle = 1'b1;
  bit   exp_err = 1'b0;
  int   exp_v = 0, exp_h = 0, exp_pd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected waveform of a whole accepted command, one record per cycle.
  task automatic build(input int p, input int w);
    int pd = 0;
    int wm = (w == 0) ? 1 : w;
    q.delete();
    repeat (SETTLE) q.push_back('{PH_SET, 0});
    for (int i = 0; i < p; i++) begin
      repeat (wm) q.push_back('{PH_PUL, pd});
      pd = (pd < 255) ? pd + 1 : 255;
      if (i < p - 1) repeat (GAP) q.push_back('{PH_GAP, pd});
    end
    repeat (SETTLE) q.push_back('{PH_REL, pd});
    q.push_back('{PH_DONE, pd});
  endtask

  // One clock: update the model for the coming edge, clock, then compare every output.
  task automatic step();
    bit en_exp;
    exp_err = 1'b0;
    if (rst) begin
      q.delete();
      exp_pd = 0; exp_v = 0; exp_h = 0;
    end else if (cur_idle && cmd_valid) begin
      if (int'(cmd_row) >= NUM_ROWS || int'(cmd_col) >= NUM_COLS) begin
        exp_err = 1'b1;
      end else begin
        exp_v = cmd_row;
        exp_h = cmd_col;
        build(cmd_pulses, cmd_width);
      end
    end else if (!cur_idle && abort && cur.ph inside {PH_SET, PH_PUL, PH_GAP}) begin
      int pd = q[0].pd;
      q.delete();
      repeat (SETTLE) q.push_back('{PH_REL, pd});
      q.push_back('{PH_DONE, pd});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      cur_idle = 1'b0;
    end else begin
      cur = '{PH_IDLE, exp_pd};
      cur_idle = 1'b1;
    end
    exp_pd = cur.pd;
    en_exp = cur.ph inside {PH_SET, PH_PUL, PH_GAP, PH_REL};
    chk("cmd_ready", cmd_ready, cur_idle);
    chk("enables", {dec_v_en, dec_h_en, drain_sel_en, gate_sel_en}, en_exp ? 4'hF : 4'h0);
    chk("prog_en", prog_en, cur.ph == PH_PUL);
    chk("busy", busy, en_exp);
    chk("done", done, cur.ph == PH_DONE);
    chk("err", err, exp_err);
    chk("pulses_done", pulses_done, cur.pd);
    chk("dec_v_addr", dec_v_addr, exp_v);
    chk("dec_h_addr", dec_h_addr, exp_h);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cur_idle && n < 2000) begin
      step();
      n++;
    end
    chk("idle_timeout", cur_idle, 1);
  endtask

  // Issue one command, optionally abort before edge abort_at (1 = accept edge); returns edges until done.
  task automatic run_cmd(input int r, input int c, input int p, input int w,
                         input int abort_at, output int lat);
    bit seen = 1'b0;
    cmd_valid = 1'b1; cmd_row = ADDR_W'(r); cmd_col = ADDR_W'(c);
    cmd_pulses = 8'(p); cmd_width = CNT_W'(w);
    step();
    cmd_valid = 1'b0;
    lat = 1;
    while (!seen && lat < 3000) begin
      lat++;
      abort = (lat == abort_at);
      step();
      abort = 1'b0;
      seen = done;
    end
    chk("done_timeout", seen, 1);
  endtask

  initial begin
    int lat;
    repeat (3) begin
      rst = 1'b1;
      step();
    end
    step();

    // Nominal command from the test plan.
    run_cmd(3, 9, 2, 5, 0, lat);
    chk("lat_nominal", lat, 21);
    chk("pd_nominal", pulses_done, 2);
    step();

    // Out-of-range row: error strobe only.
    cmd_valid = 1'b1; cmd_row = 5'd8; cmd_col = 5'd0;
    step();
    cmd_valid = 1'b0;
    chk("err_strobe", err, 1);
    chk("err_busy", busy, 0);
    step();

    // Zero pulses: settle then release.
    run_cmd(1, 2, 0, 7, 0, lat);
    chk("lat_zero_pulses", lat, 9);
    chk("pd_zero_pulses", pulses_done, 0);
    step();

    // Zero width clamps to one-cycle pulses.
    run_cmd(7, 15, 3, 0, 0, lat);
    chk("lat_zero_width", lat, 4 + 3 + 2 * GAP + SETTLE + 1);
    step();

    // Long train aborted inside the third pulse (cycles 209..308), then back-to-back valid.
    run_cmd(5, 4, 10, 100, 220, lat);
    chk("lat_abort", lat, 220 + SETTLE);
    chk("pd_abort", pulses_done, 2);
    cmd_valid = 1'b1; cmd_row = 5'd2; cmd_col = 5'd3; cmd_pulses = 8'd1; cmd_width = 16'd2;
    chk("b2b_not_ready_in_done", cmd_ready, 0);
    step();
    step();
    cmd_valid = 1'b0;
    chk("b2b_accepted", busy, 1);
    wait_idle();

    // Reset in the middle of a pulse.
    cmd_valid = 1'b1; cmd_row = 5'd6; cmd_col = 5'd1; cmd_pulses = 8'd3; cmd_width = 16'd10;
    step();
    cmd_valid = 1'b0;
    repeat (6) step();
    chk("pre_rst_prog", prog_en, 1);
    rst = 1'b1;
    step();
    chk("rst_prog", prog_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);

    // Random commands, random valid timing and occasional aborts.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_row    = ADDR_W'($urandom_range(0, 9));
      cmd_col    = ADDR_W'($urandom_range(0, 18));
      cmd_pulses = 8'($urandom_range(0, 4));
      cmd_width  = CNT_W'($urandom_range(0, 5));
      abort      = ($urandom_range(0, 40) == 0);
      step();
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fg_prog_sequencer.md
Name: fg_prog_sequencer

Overview:
- Command-driven sequencer directly upstream of an island's programming mux.
- Takes one floating-gate programming command (row, col, pulse count, pulse width) per handshake.
- Drives the vertical/horizontal Vinj 2-to-4 decoder address buses, the gate-mux / drain-select enables and the injection enable, with timed address settling, pulse trains and release.
- One instance per island; the island's matrix dimensions bound the legal addresses.

Parameters:
- NUM_ROWS, 8, rows in the island matrix (drain-select count).
- NUM_COLS, 16, columns in the island matrix (gate-mux count).
- ADDR_W, 5, decoder address width (bits on both decoders).
- SETTLE_CYC, 4, address-settle cycles before the first pulse and before release (≥1).
- GAP_CYC, 2, idle cycles between consecutive pulses (≥1).
- CNT_W, 16, pulse-width counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_row  in  ADDR_W  target row → vertical decoder.
- cmd_col  in  ADDR_W  target column → horizontal decoder.
- cmd_pulses  in  8  number of injection pulses.
- cmd_width  in  CNT_W  pulse high time in cycles.
- abort  in  1  terminate current command.
- dec_v_addr  out  ADDR_W  vertical decoder address.
- dec_h_addr  out  ADDR_W  horizontal decoder address.
- dec_v_en  out  1  vertical decoder enable.
- dec_h_en  out  1  horizontal decoder enable.
- drain_sel_en  out  1  drain-select switch enable.
- gate_sel_en  out  1  gate-mux switch enable.
- prog_en  out  1  injection pulse (prog_switch).
- busy  out  1  command in progress.
- done  out  1  one-cycle completion strobe.
- err  out  1  one-cycle strobe: command rejected (address out of range).
- pulses_done  out  8  pulses issued for current/last command.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. Reset is synchronous and overrides every state; reset mid-pulse drops prog_en and all enables on that edge.
- All outputs are registered.
- FSM states: IDLE, SETUP, PULSE, GAP, RELEASE, DONE.
- Handshake: cmd_ready = (state==IDLE) and not rst. Accept on edge with cmd_valid&&cmd_ready; command fields are latched.
- Range check at accept: cmd_row ≥ NUM_ROWS or cmd_col ≥ NUM_COLS → err=1 the next cycle, stay IDLE, no outputs change.
- Valid accept (edge T0) → SETUP from T0+1:
  - dec_v_addr/dec_h_addr loaded.
  - dec_*_en, drain_sel_en and gate_sel_en =1.
  - busy=1; pulses_done cleared.
  - SETUP lasts exactly SETTLE_CYC cycles.
- SETUP → PULSE, or → RELEASE if cmd_pulses==0.
- PULSE:
  - prog_en=1 for exactly max(cmd_width,1) cycles.
  - pulses_done increments on the last PULSE cycle (visible the next cycle).
  - Then GAP if pulses remain, else RELEASE.
- GAP: prog_en=0 for exactly GAP_CYC cycles, then PULSE. No GAP after the final pulse.
- RELEASE:
  - prog_en=0; enables and addresses held for SETTLE_CYC cycles.
  - On exit, enables drop to 0; addresses hold their last value.
- DONE: one cycle with done=1, busy=0, enables 0 → IDLE. cmd_ready=1 the following cycle.
- abort, sampled in SETUP/PULSE/GAP: next cycle prog_en=0 and state=RELEASE, which runs the full settle; done still asserts. abort in RELEASE/DONE/IDLE is ignored.
- Enables are never low while prog_en=1. prog_en never rises in the same cycle as an address change.
- pulses_done saturates at 255; it holds after DONE until the next valid accept.

Test Plan:
- Reset → cmd_ready=1, all other outputs 0. Assert rst during PULSE → next cycle prog_en=0, busy=0, cmd_ready=1.
- row=3, col=9, pulses=2, width=5, SETTLE=4, GAP=2 → accept T0:
  - dec_v_addr=3, dec_h_addr=9, enables from T0+1.
  - prog_en high T0+5..T0+9, low T0+10..11, high T0+12..16.
  - Enables drop at T0+21; done at T0+21; pulses_done=2.
- row=8 (NUM_ROWS=8), col=0 → err pulse at T0+1, busy stays 0, no enable toggles, cmd_ready stays 1.
- pulses=0 → SETUP then RELEASE, prog_en never high, done at T0+9, pulses_done=0.
- width=0, pulses=3 → three 1-cycle prog_en pulses separated by 2 low cycles.
- pulses=10, width=100; abort in 3rd pulse → prog_en low next cycle, pulses_done=2, enables held 4 cycles, then done. A back-to-back cmd_valid is accepted only in the cycle after done.
